// File: rtl/div_pkg.sv
// div_pkg: shared FSM state type and counter-width helper for the sequential divider.
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/div_restore_step.sv
// div_restore_step: one radix-2 restoring step (shift in a dividend bit, trial-subtract, select).
module div_restore_step #(
  parameter int WIDTH_D = 8
) (
  input  logic [WIDTH_D:0]   rem_i,
  input  logic               bit_i,
  input  logic [WIDTH_D-1:0] dsr_i,
  output logic [WIDTH_D:0]   rem_o,
  output logic               q_o
);
  logic [WIDTH_D+1:0] sh;
  logic [WIDTH_D+2:0] diff;
  always_comb begin
    sh = {rem_i, bit_i};
    diff = {1'b0, sh} - {3'b000, dsr_i};
    q_o = ~diff[WIDTH_D+2];
    rem_o = q_o ? (WIDTH_D+1)'(diff) : (WIDTH_D+1)'(sh);
  end
endmodule

// File: rtl/seq_div_signed.sv
// seq_div_signed: sequential signed divider, truncating quotient/remainder, one quotient bit per cycle.
module seq_div_signed
  import div_pkg::*;
#(
  parameter int WIDTH_N = 16,
  parameter int WIDTH_D = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_N-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_N-1:0] quotient,
  output logic [WIDTH_D-1:0] remainder,
  output logic               div_by_zero,
  output logic               overflow
);
  localparam int CW = clog2(WIDTH_N) > 0 ? clog2(WIDTH_N) : 1;
  state_t state_q, state_d;
  logic sn_q, sn_d, sd_q, sd_d, dbz_q, dbz_d, ovf_q, ovf_d, step_q;
  logic [WIDTH_D-1:0] dsr_q, dsr_d, r_q, r_d;
  logic [WIDTH_D:0] acc_q, acc_d, step_rem;
  logic [WIDTH_N-1:0] quo_q, quo_d, q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;

  div_restore_step #(.WIDTH_D(WIDTH_D)) u_step (
    .rem_i(acc_q), .bit_i(quo_q[WIDTH_N-1]), .dsr_i(dsr_q), .rem_o(step_rem), .q_o(step_q)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;

  always_comb
    state_d = state_q == IDLE ? (in_valid ? (divisor == '0 ? DONE : CALC) : IDLE)
            : state_q == CALC ? (cnt_q == '0 ? FIX : CALC)
            : state_q == FIX  ? DONE
            : (out_ready ? IDLE : DONE);

  always_comb begin
    in_ready = state_q == IDLE;
    out_valid = state_q == DONE;
    quotient = q_q;
    remainder = r_q;
    div_by_zero = dbz_q;
    overflow = ovf_q;
  end

  // quo_q starts as |dividend| and fills with quotient bits as the magnitude shifts out.
  always_comb begin
    sn_d = sn_q;
    sd_d = sd_q;
    dsr_d = dsr_q;
    acc_d = acc_q;
    quo_d = quo_q;
    cnt_d = cnt_q;
    q_d = q_q;
    r_d = r_q;
    dbz_d = dbz_q;
    ovf_d = ovf_q;
    if (state_q == IDLE && in_valid) begin
      sn_d = dividend[WIDTH_N-1];
      sd_d = divisor[WIDTH_D-1];
      quo_d = dividend[WIDTH_N-1] ? -dividend : dividend;
      dsr_d = divisor[WIDTH_D-1] ? -divisor : divisor;
      acc_d = '0;
      cnt_d = CW'(WIDTH_N - 1);
      if (divisor == '0) begin
        q_d = '1;
        r_d = '0;
        dbz_d = 1'b1;
        ovf_d = 1'b0;
      end
    end else if (state_q == CALC) begin
      acc_d = step_rem;
      quo_d = {quo_q[WIDTH_N-2:0], step_q};
      cnt_d = cnt_q - CW'(1);
    end else if (state_q == FIX) begin
      q_d = (sn_q ^ sd_q) ? -quo_q : quo_q;
      r_d = sn_q ? -acc_q[WIDTH_D-1:0] : acc_q[WIDTH_D-1:0];
      dbz_d = 1'b0;
      // A magnitude quotient of 2^(WIDTH_N-1) with both signs negative only arises from MIN / -1.
      ovf_d = sn_q & sd_q & quo_q[WIDTH_N-1];
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sn_q <= 1'b0;
      sd_q <= 1'b0;
      dsr_q <= '0;
      acc_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      q_q <= '0;
      r_q <= '0;
      dbz_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      sn_q <= sn_d;
      sd_q <= sd_d;
      dsr_q <= dsr_d;
      acc_q <= acc_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
      q_q <= q_d;
      r_q <= r_d;
      dbz_q <= dbz_d;
      ovf_q <= ovf_d;
    end
endmodule

// File: tb/tb_seq_div_signed.sv
// tb_seq_div_signed: directed table, hold/reset sequences and random stream against a reference model.
module tb_seq_div_signed;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, div_by_zero, overflow;
  logic [15:0] dividend = '0, quotient;
  logic [7:0] divisor = '0, remainder;
  int n_cmp = 0, n_err = 0;

  seq_div_signed #(.WIDTH_N(16), .WIDTH_D(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
    logic        ovf;
    int          lat;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                output logic [15:0] q, output logic [7:0] r,
                                output logic dbz, output logic ovf, output int lat);
    int ai, bi;
    ai = int'($signed(a));
    bi = int'($signed(b));
    dbz = 1'b0;
    ovf = 1'b0;
    lat = 18;
    if (bi == 0) begin
      q = 16'hFFFF; r = 8'h00; dbz = 1'b1; lat = 1;
    end else if (ai == -32768 && bi == -1) begin
      q = 16'h8000; r = 8'h00; ovf = 1'b1;
    end else begin
      q = 16'(ai / bi);
      r = 8'(ai % bi);
    end
  endfunction

  task automatic start(input logic [15:0] a, input logic [7:0] b);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_wait", in_ready, 1);
    dividend = a;
    divisor = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor = 8'($urandom);
  endtask

  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] q, input logic [7:0] r,
                              input logic dbz, input logic ovf, input int lat, input int got_lat);
    chk({tag, "_latency"}, got_lat, lat);
    chk({tag, "_quotient"}, quotient, q);
    chk({tag, "_remainder"}, remainder, r);
    chk({tag, "_div_by_zero"}, div_by_zero, dbz);
    chk({tag, "_overflow"}, overflow, ovf);
  endtask

  initial begin
    int lat;
    logic [15:0] a, eq;
    logic [7:0] b, er;
    logic edbz, eovf;
    int elat;

    vecs[0] = '{16'd100,   8'd7,    16'd14,   8'd2,    1'b0, 1'b0, 18};
    vecs[1] = '{16'hFF9C,  8'd7,    16'hFFF2, 8'hFE,   1'b0, 1'b0, 18};
    vecs[2] = '{16'd100,   8'hF9,   16'hFFF2, 8'd2,    1'b0, 1'b0, 18};
    vecs[3] = '{16'hFF9C,  8'hF9,   16'd14,   8'hFE,   1'b0, 1'b0, 18};
    vecs[4] = '{16'h8000,  8'hFF,   16'h8000, 8'h00,   1'b0, 1'b1, 18};
    vecs[5] = '{16'h7FFF,  8'h80,   16'hFF01, 8'h7F,   1'b0, 1'b0, 18};
    vecs[6] = '{16'd1234,  8'd0,    16'hFFFF, 8'h00,   1'b1, 1'b0, 1};
    vecs[7] = '{16'h8000,  8'd1,    16'h8000, 8'h00,   1'b0, 1'b0, 18};
    vecs[8] = '{16'h8000,  8'h80,   16'd256,  8'h00,   1'b0, 1'b0, 18};
    vecs[9] = '{16'd0,     8'd5,    16'd0,    8'h00,   1'b0, 1'b0, 18};

    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_flags", {div_by_zero, overflow}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      start(vecs[i].a, vecs[i].b);
      wait_result(lat);
      check_result($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ovf, vecs[i].lat, lat);
      @(negedge clk);
      chk($sformatf("vec%0d_valid_drop", i), out_valid, 0);
      chk($sformatf("vec%0d_ready_back", i), in_ready, 1);
    end

    out_ready = 1'b0;
    start(16'd100, 8'd7);
    wait_result(lat);
    chk("hold_latency", lat, 18);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_data", {quotient, remainder}, {16'd14, 8'd2});
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("hold_release_in_ready", in_ready, 1);
    chk("hold_release_out_valid", out_valid, 0);

    start(16'd20000, 8'd3);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midcalc_rst_in_ready", in_ready, 1);
    chk("midcalc_rst_out_valid", out_valid, 0);
    chk("midcalc_rst_data", {quotient, remainder, div_by_zero, overflow}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start(16'd50, 8'd5);
    wait_result(lat);
    check_result("after_rst", 16'd10, 8'd0, 1'b0, 1'b0, 18, lat);

    for (int i = 0; i < 100; i++) begin
      a = 16'($urandom);
      b = 8'($urandom);
      if (i % 17 == 0) b = 8'd0;
      if (i % 23 == 0) begin a = 16'h8000; b = 8'hFF; end
      if (i % 29 == 0) a = 16'h8000;
      model(a, b, eq, er, edbz, eovf, elat);
      @(negedge clk);
      start(a, b);
      wait_result(lat);
      check_result($sformatf("rand%0d_%h_%h", i, a, b), eq, er, edbz, eovf, elat, lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
